// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package riscv_muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
  import riscv_muldiv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    diff    = shifted - {1'b0, div_i};
    // remainder < divisor, so a set top bit of diff can only mean a borrow
    if (diff[W]) begin
      rem_o = shifted[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end else begin
      rem_o = diff[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, 32 cycles per op, start/busy/done handshake.
// Multiply ops are only built when MULDIV_MUL_EN is defined; otherwise they complete as illegal.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out,
  output logic            illegal
);

  import riscv_muldiv_pkg::*;

  localparam int CW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic            neg_q, rneg_q;
  logic [4:0]      rd_pend_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q;
  logic            illegal_q;

  logic            load, step, last;

  logic            sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            spec_hit, ill_in;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    sgn_a = (op == MD_DIV) || (op == MD_REM) || (op == MD_MUL) ||
            (op == MD_MULH) || (op == MD_MULHSU);
    sgn_b = (op == MD_DIV) || (op == MD_REM) || (op == MD_MUL) || (op == MD_MULH);
    a_neg = sgn_a & rs1_val[XLEN-1];
    b_neg = sgn_b & rs2_val[XLEN-1];
    a_mag = a_neg ? -rs1_val : rs1_val;
    b_mag = b_neg ? -rs2_val : rs2_val;

    spec_hit = 1'b0;
    ill_in   = 1'b0;
    spec_res = '0;
    if (op[2]) begin
      if (rs2_val == '0) begin
        spec_hit = 1'b1;
        spec_res = (op == MD_DIV || op == MD_DIVU) ? DIV0_Q : rs1_val;
      end else if (sgn_b && rs1_val == INT_MIN && rs2_val == DIV0_Q) begin
        spec_hit = 1'b1;
        spec_res = (op == MD_DIV) ? INT_MIN : '0;
      end
    end
`ifndef MULDIV_MUL_EN
    else begin
      spec_hit = 1'b1;
      ill_in   = 1'b1;
    end
`endif
  end

  logic [XLEN-1:0] div_rem, div_quo;

  div_step #(.W(XLEN)) u_div_step (
    .rem_i (hi_q),
    .quo_i (lo_q),
    .div_i (b_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  logic [XLEN-1:0] hi_step, lo_step;
`ifdef MULDIV_MUL_EN
  logic [XLEN:0]   mul_sum;
  logic [2*XLEN-1:0] prod;
`endif

  always_comb begin
    hi_step = div_rem;
    lo_step = div_quo;
`ifdef MULDIV_MUL_EN
    // shift-add: multiplier sits in lo_q and drains out as the product shifts in
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    if (!op_q[2]) begin
      {hi_step, lo_step} = {mul_sum, lo_q[XLEN-1:1]};
    end
`endif
  end

  logic [XLEN-1:0] quo_fix, rem_fix, fin;

  always_comb begin
    quo_fix = neg_q ? -lo_step : lo_step;
    rem_fix = rneg_q ? -hi_step : hi_step;
    fin     = '0;
`ifdef MULDIV_MUL_EN
    prod = {hi_step, lo_step};
    if (neg_q) prod = -prod;
`endif
    case (op_q)
      MD_DIV, MD_DIVU: fin = quo_fix;
      MD_REM, MD_REMU: fin = rem_fix;
`ifdef MULDIV_MUL_EN
      MD_MUL:          fin = prod[XLEN-1:0];
      default:         fin = prod[2*XLEN-1:XLEN];
`else
      default:         fin = '0;
`endif
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = (cnt_q == CW'(XLEN - 1));
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = spec_hit ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      rd_pend_q <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else if (load) begin
      op_q      <= op;
      hi_q      <= '0;
      lo_q      <= op[2] ? a_mag : b_mag;
      b_q       <= op[2] ? b_mag : a_mag;
      neg_q     <= a_neg ^ b_neg;
      rneg_q    <= a_neg;
      rd_pend_q <= rd_in;
      if (spec_hit) begin
        result_q  <= spec_res;
        rd_q      <= rd_in;
        illegal_q <= ill_in;
      end
    end else if (step) begin
      hi_q <= hi_step;
      lo_q <= lo_step;
      if (last) begin
        result_q  <= fin;
        rd_q      <= rd_pend_q;
        illegal_q <= 1'b0;
      end
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign result  = result_q;
  assign rd_out  = rd_q;
  assign illegal = illegal_q;
  assign we_out  = done && (rd_q != 5'd0) && !illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops
// against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        busy, done, we_out, illegal;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_run  = 0;
  int n_fail = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out),
    .we_out  (we_out),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef MULDIV_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  // returns {illegal, result}
  function automatic logic [32:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (!o[2] && !MUL_EN) return {1'b1, 32'd0};
    case (o)
      3'd0: begin p = sa * sb; pb = p; return {1'b0, pb[31:0]}; end
      3'd1: begin p = sa * sb; pb = p; return {1'b0, pb[63:32]}; end
      3'd2: begin p = sa * ub; pb = p; return {1'b0, pb[63:32]}; end
      3'd3: begin p = ua * ub; pb = p; return {1'b0, pb[63:32]}; end
      3'd4: begin
        if (b == 0) return {1'b0, 32'hFFFF_FFFF};
        p = sa / sb; pb = p; return {1'b0, pb[31:0]};
      end
      3'd5: return (b == 0) ? {1'b0, 32'hFFFF_FFFF} : {1'b0, a / b};
      3'd6: begin
        if (b == 0) return {1'b0, a};
        p = sa % sb; pb = p; return {1'b0, pb[31:0]};
      end
      default: return (b == 0) ? {1'b0, a} : {1'b0, a % b};
    endcase
  endfunction

  // Drives one op at the current (post-edge) time; returns what was seen in the done cycle.
  // edge_n = number of clock edges after the start edge at which done was seen, -1 on timeout.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, output logic [31:0] res, output logic [4:0] rdo,
                        output logic weo, output logic ill, output int edge_n);
    op = o; rs1_val = a; rs2_val = b; rd_in = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs1_val = $urandom; rs2_val = $urandom;
    rd_in = 5'($urandom_range(0, 31)); op = 3'($urandom_range(0, 7));
    edge_n = 0;
    while (!done && edge_n < 64) begin
      @(posedge clk); #1;
      edge_n++;
    end
    if (!done) edge_n = -1;
    res = result; rdo = rd_out; weo = we_out; ill = illegal;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_run++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_run++; if (rd_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd_out: got %0d want 0", rd_out); end
    n_run++; if (we_out !== 1'b0) begin n_fail++; $display("FAIL reset_we_out: got %b want 0", we_out); end
    n_run++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  r;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_div_directed();
    vec_t v[$];
    logic [31:0] res; logic [4:0] rdo; logic weo, ill; int en;
    v.push_back('{3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 32});
    v.push_back('{3'b111, 32'd100, 32'd7, 5'd6, 32'd2, 32});
    v.push_back('{3'b100, -32'sd7, 32'd2, 5'd7, 32'hFFFF_FFFD, 32});
    v.push_back('{3'b110, -32'sd7, 32'd2, 5'd8, 32'hFFFF_FFFF, 32});
    v.push_back('{3'b100, 32'd7, -32'sd2, 5'd9, 32'hFFFF_FFFD, 32});
    foreach (v[i]) begin
      run_op(v[i].o, v[i].a, v[i].b, v[i].r, res, rdo, weo, ill, en);
      n_run++; if (res !== v[i].exp) begin n_fail++; $display("FAIL div_result[%0d]: got %h want %h", i, res, v[i].exp); end
      n_run++; if (en !== v[i].lat) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, en, v[i].lat); end
      n_run++; if (rdo !== v[i].r) begin n_fail++; $display("FAIL div_rd_out[%0d]: got %0d want %0d", i, rdo, v[i].r); end
      n_run++; if (weo !== 1'b1) begin n_fail++; $display("FAIL div_we_out[%0d]: got %b want 1", i, weo); end
      n_run++; if (ill !== 1'b0) begin n_fail++; $display("FAIL div_illegal[%0d]: got %b want 0", i, ill); end
    end
  endtask

  task automatic test_special();
    vec_t v[$];
    logic [31:0] res; logic [4:0] rdo; logic weo, ill; int en;
    v.push_back('{3'b100, 32'd9, 32'd0, 5'd1, 32'hFFFF_FFFF, 0});
    v.push_back('{3'b111, 32'd5, 32'd0, 5'd2, 32'd5, 0});
    v.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 0});
    v.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'd0, 0});
    foreach (v[i]) begin
      run_op(v[i].o, v[i].a, v[i].b, v[i].r, res, rdo, weo, ill, en);
      n_run++; if (res !== v[i].exp) begin n_fail++; $display("FAIL special_result[%0d]: got %h want %h", i, res, v[i].exp); end
      n_run++; if (en !== v[i].lat) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d want %0d", i, en, v[i].lat); end
      n_run++; if (ill !== 1'b0) begin n_fail++; $display("FAIL special_illegal[%0d]: got %b want 0", i, ill); end
      n_run++; if (rdo !== v[i].r) begin n_fail++; $display("FAIL special_rd_out[%0d]: got %0d want %0d", i, rdo, v[i].r); end
    end
  endtask

  task automatic test_mul();
    logic [31:0] res; logic [4:0] rdo; logic weo, ill; int en;
`ifdef MULDIV_MUL_EN
    vec_t v[$];
    v.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 32});
    v.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 32});
    v.push_back('{3'b000, 32'd3, -32'sd4, 5'd12, 32'hFFFF_FFF4, 32});
    foreach (v[i]) begin
      run_op(v[i].o, v[i].a, v[i].b, v[i].r, res, rdo, weo, ill, en);
      n_run++; if (res !== v[i].exp) begin n_fail++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, v[i].exp); end
      n_run++; if (en !== v[i].lat) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, en, v[i].lat); end
      n_run++; if (ill !== 1'b0) begin n_fail++; $display("FAIL mul_illegal[%0d]: got %b want 0", i, ill); end
      n_run++; if (weo !== 1'b1) begin n_fail++; $display("FAIL mul_we_out[%0d]: got %b want 1", i, weo); end
    end
`else
    run_op(3'b000, 32'd3, 32'd4, 5'd10, res, rdo, weo, ill, en);
    n_run++; if (en !== 0) begin n_fail++; $display("FAIL nomul_latency: got %0d want 0", en); end
    n_run++; if (ill !== 1'b1) begin n_fail++; $display("FAIL nomul_illegal: got %b want 1", ill); end
    n_run++; if (res !== 32'd0) begin n_fail++; $display("FAIL nomul_result: got %h want 0", res); end
    n_run++; if (weo !== 1'b0) begin n_fail++; $display("FAIL nomul_we_out: got %b want 0", weo); end
`endif
  endtask

  task automatic test_busy_ignore();
    int en;
    int extra;
    op = 3'b101; rs1_val = 32'd1000; rs2_val = 32'd10; rd_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    en = 0;
    while (!done && en < 64) begin
      // stray requests while busy, including the very last CALC cycle
      if (en == 5 || en == 31) begin
        start = 1'b1; op = 3'b101; rs1_val = 32'd50; rs2_val = 32'd5; rd_in = 5'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      en++;
    end
    start = 1'b0;
    if (!done) en = -1;
    n_run++; if (en !== 32) begin n_fail++; $display("FAIL busy_latency: got %0d want 32", en); end
    n_run++; if (result !== 32'd100) begin n_fail++; $display("FAIL busy_result: got %h want %h", result, 32'd100); end
    n_run++; if (rd_out !== 5'd3) begin n_fail++; $display("FAIL busy_rd_out: got %0d want 3", rd_out); end
    // a stray start during the done cycle must be ignored too
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_run++; if (extra !== 0) begin n_fail++; $display("FAIL busy_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_flush();
    logic [31:0] res; logic [4:0] rdo; logic weo, ill; int en;
    int dones;
    run_op(3'b101, 32'd100, 32'd7, 5'd5, res, rdo, weo, ill, en);
    op = 3'b111; rs1_val = 32'd99; rs2_val = 32'd10; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
    n_run++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result_held: got %h want %h", result, 32'd14); end
    n_run++; if (rd_out !== 5'd5) begin n_fail++; $display("FAIL flush_rd_held: got %0d want 5", rd_out); end
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_run++; if (dones !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d want 0", dones); end
    op = 3'b101; rs1_val = 32'd10; rs2_val = 32'd0; rd_in = 5'd4; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_run++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL flush_beats_start: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_rd0();
    logic [31:0] res; logic [4:0] rdo; logic weo, ill; int en;
    run_op(3'b101, 32'd20, 32'd3, 5'd0, res, rdo, weo, ill, en);
    n_run++; if (en !== 32) begin n_fail++; $display("FAIL rd0_latency: got %0d want 32", en); end
    n_run++; if (res !== 32'd6) begin n_fail++; $display("FAIL rd0_result: got %h want 6", res); end
    n_run++; if (weo !== 1'b0) begin n_fail++; $display("FAIL rd0_we_out: got %b want 0", weo); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [4:0] rdo; logic weo, ill; int en;
    run_op(3'b101, 32'd77, 32'd7, 5'd13, res, rdo, weo, ill, en);
    op = 3'b100; rs1_val = 32'd1234; rs2_val = 32'd3; rd_in = 5'd14; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_run++; if ({busy, done, we_out, illegal} !== 4'b0000) begin n_fail++; $display("FAIL midreset_flags: got %b want 0000", {busy, done, we_out, illegal}); end
    n_run++; if (result !== 32'd0) begin n_fail++; $display("FAIL midreset_result: got %h want 0", result); end
    n_run++; if (rd_out !== 5'd0) begin n_fail++; $display("FAIL midreset_rd_out: got %0d want 0", rd_out); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got %b want 0", busy); end
    run_op(3'b110, 32'd1234, 32'd100, 5'd2, res, rdo, weo, ill, en);
    n_run++; if (res !== 32'd34 || en !== 32) begin n_fail++; $display("FAIL midreset_recover: got %h/%0d want %h/32", res, en, 32'd34); end
  endtask

  task automatic test_random();
    logic [31:0] res; logic [4:0] rdo; logic weo, ill; int en;
    logic [2:0] o; logic [31:0] a, b; logic [4:0] r;
    logic [32:0] exp; logic sp; int exp_lat; int sel;
    for (int k = 0; k < 60; k++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) begin a = 32'($urandom_range(0, 100)); b = -32'($urandom_range(1, 9)); end
      r = 5'($urandom_range(0, 31));
      exp = ref_op(o, a, b);
      sp = o[2] && (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      if (!o[2] && !MUL_EN) sp = 1'b1;
      exp_lat = sp ? 0 : 32;
      run_op(o, a, b, r, res, rdo, weo, ill, en);
      n_run++; if (res !== exp[31:0]) begin n_fail++; $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got %h want %h", k, o, a, b, res, exp[31:0]); end
      n_run++; if (ill !== exp[32]) begin n_fail++; $display("FAIL rand_illegal[%0d]: got %b want %b", k, ill, exp[32]); end
      n_run++; if (en !== exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", k, en, exp_lat); end
      n_run++; if (rdo !== r) begin n_fail++; $display("FAIL rand_rd_out[%0d]: got %0d want %0d", k, rdo, r); end
      n_run++; if (weo !== ((r != 5'd0) && !exp[32])) begin n_fail++; $display("FAIL rand_we_out[%0d]: got %b want %b", k, weo, (r != 5'd0) && !exp[32]); end
    end
  endtask

  initial begin
    test_reset();
    test_div_directed();
    test_special();
    test_mul();
    test_busy_ignore();
    test_flush();
    test_rd0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
